user_mgr_arbiter: RTL and testbench
===================================

// Module: user_mgr_arbiter
//
// PURPOSE
// - Shares the single user-domain OBI manager port into Croc between NumMgr user managers (CNN + future DMA).
// - Round-robin arbitration of A-channel requests, with up to MaxTrans outstanding transactions.
// - In-order R-channel routing back to the issuing manager via an ID FIFO.
// - Sits in user_domain between the manager-side blocks and user_mgr_obi_req_o/user_mgr_obi_rsp_i.
//
// PARAMETERS
// - NumMgr     2              number of upstream managers (>=1; 1 = pass-through with tracking)
// - MaxTrans   2              max outstanding transactions (ID FIFO depth, >=1)
// - obi_req_t  mgr_obi_req_t  OBI request struct (req, a.addr/we/be/wdata/aid)
// - obi_rsp_t  mgr_obi_rsp_t  OBI response struct (gnt, rvalid, r.rdata/err/rid)
//
// PORTS
// - clk_i           in   1          system clock
// - rst_ni          in   1          asynchronous active-low reset
// - sbr_req_i       in   NumMgr     per-manager OBI requests (obi_req_t array)
// - sbr_rsp_o       out  NumMgr     per-manager OBI responses (obi_rsp_t array)
// - mgr_req_o       out  1          merged OBI request towards Croc (obi_req_t)
// - mgr_rsp_i       in   1          OBI response from Croc (obi_rsp_t)
// - idle_o          out  1          high when no transaction is outstanding and none is pending
// - spurious_rsp_o  out  1          one-cycle pulse when rvalid arrives with an empty ID FIFO
//
// BEHAVIOUR
// - Reset values: all sbr_rsp_o.gnt/rvalid=0; mgr_req_o.req=0; RR pointer=0; lock=0; FIFO empty; idle_o=1; spurious_rsp_o=0.
// - Arbitration:
//   - Combinational winner among sbr_req_i[i].req, searched from the RR pointer upward with wrap.
//   - mgr_req_o = winner's A-channel; mgr_req_o.req = winner valid && !fifo_full.
// - Grant:
//   - sbr_rsp_o[w].gnt = mgr_rsp_i.gnt && mgr_req_o.req; all other gnt=0.
//   - A handshake is mgr_req_o.req && mgr_rsp_i.gnt. Zero added latency.
// - Lock (OBI stability rule):
//   - States UNLOCKED / LOCKED.
//   - UNLOCKED -> LOCKED when mgr_req_o.req && !gnt. Store lock_idx = winner.
//   - While LOCKED, winner is forced to lock_idx regardless of other requests.
//   - LOCKED -> UNLOCKED on handshake.
// - RR update: on handshake, pointer <= winner+1 (mod NumMgr). Pointer is held otherwise.
// - ID FIFO:
//   - On handshake, push winner index.
//   - On mgr_rsp_i.rvalid with non-empty FIFO, pop and route rvalid/r to the popped index.
//   - Other managers see rvalid=0 and r='0.
// - FIFO full:
//   - mgr_req_o.req is forced to 0, even if a pop occurs in the same cycle (conservative).
//   - The lock state is kept.
// - Simultaneous push/pop when not full: both happen, and occupancy is unchanged.
// - Spurious response: rvalid with empty FIFO is dropped, pulses spurious_rsp_o, and leaves state unchanged.
// - idle_o = FIFO empty && no sbr_req_i[i].req asserted.
// - rid/aid are passed through unchanged. Routing uses only the FIFO; responses from Croc are in order.
// - Reset mid-operation: all outstanding transactions are forgotten, and late rvalids are flagged as spurious.
//
// CONFIGURATION
// - USER_MGR_ARB_FIXED_PRIO_EN defined:
//   - Fixed priority, lowest index wins.
//   - RR pointer is removed; the lock still applies.
// - Undefined (default): round-robin as above.
//
// STRUCTURE
// - user_pkg additions:
//   - NumUserMgr.
//   - enum user_mgr_idx_e {UserMgrCnn=0, UserMgrDma=1}.
//   - UserMgrMaxTrans.
// - Sub-module user_mgr_arb_id_fifo:
//   - Depth MaxTrans, width $clog2(NumMgr) (min 1).
//   - Ports push/pop/full/empty/data.
//   - Async active-low reset.
// - Top level holds the arbiter, lock FSM and response routing.
//
// TESTING
// - Single manager 0 write 0x1000, gnt same cycle -> mgr_req_o.req=1 that cycle; rsp_o[0].gnt=1; rvalid next cycle routed to mgr 0 only.
// - Both managers request continuously, gnt always 1 -> grants alternate 0,1,0,1; fixed-prio build grants 0 only.
// - Mgr 1 requests, gnt held 0 for 3 cycles while mgr 0 raises req -> mgr_req_o stays mgr 1's addr/wdata until granted; then mgr 0.
// - MaxTrans=2, two grants with no rvalid -> req forced 0 (full); on rvalid, first rsp goes to first issuer and req resumes next cycle.
// - rvalid injected after reset with nothing outstanding -> spurious_rsp_o pulses 1 cycle; no rsp_o[i].rvalid.
// - rst_ni asserted with 2 outstanding -> all outputs at reset values asynchronously; idle_o=1 after release.

Source files
------------

// File: rtl/user_mgr_arbiter_pkg.sv
// Shared types and constants for the user-domain manager arbiter.
//
// Contents:
//   NumUserMgr / UserMgrMaxTrans : default manager count and outstanding depth
//   user_mgr_idx_e               : manager slot assignment (CNN, DMA)
//   mgr_obi_req_t / mgr_obi_rsp_t: OBI request/response structs on the manager port
//   lock_state_e                 : A-channel lock FSM states
//   idx_width()                  : index width helper, never narrower than one bit
package user_mgr_arbiter_pkg;

    localparam int unsigned NumUserMgr      = 2;
    localparam int unsigned UserMgrMaxTrans = 2;

    typedef enum logic [0:0] {
        UserMgrCnn = 1'b0,
        UserMgrDma = 1'b1
    } user_mgr_idx_e;

    localparam int unsigned ObiAddrW = 32;
    localparam int unsigned ObiDataW = 32;
    localparam int unsigned ObiIdW   = 1;

    typedef struct packed {
        logic [ObiAddrW-1:0]   addr;
        logic                  we;
        logic [ObiDataW/8-1:0] be;
        logic [ObiDataW-1:0]   wdata;
        logic [ObiIdW-1:0]     aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        mgr_obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [ObiDataW-1:0] rdata;
        logic                err;
        logic [ObiIdW-1:0]   rid;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_mgr_arbiter_id_fifo.sv
// In-order FIFO of manager indices, one entry per outstanding transaction.
// The head entry names the manager that owns the next R-channel beat.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (FIFO empties)
//   push, wdata: enqueue wdata (ignored when full)
//   pop, rdata : dequeue head (ignored when empty); rdata is the current head
//   full, empty: occupancy flags
module user_mgr_arb_id_fifo
    import user_mgr_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CntW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/user_mgr_arbiter.sv
// Shares the single user-domain OBI manager port between NumMgr managers.
// A-channel: round-robin arbitration (fixed priority, lowest index first, when
// USER_MGR_ARB_FIXED_PRIO_EN is defined), with a lock that holds the current
// winner from an ungranted request until its handshake. R-channel: responses
// are routed in order using a FIFO of issuer indices, up to MaxTrans deep.
//
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   sbr_req_i[]    : per-manager OBI requests
//   sbr_rsp_o[]    : per-manager OBI responses (gnt to winner, rvalid/r to issuer)
//   mgr_req_o      : merged request towards Croc
//   mgr_rsp_i      : response from Croc
//   idle_o         : nothing outstanding and no request pending
//   spurious_rsp_o : rvalid seen with nothing outstanding (dropped)
//
// Lock FSM:
//   state    | meaning
//   UNLOCKED | winner chosen freely by the arbiter
//   LOCKED   | request issued but not granted; winner pinned to lock_idx
module user_mgr_arbiter
    import user_mgr_arbiter_pkg::*;
#(
    parameter int unsigned NumMgr   = NumUserMgr,
    parameter int unsigned MaxTrans = UserMgrMaxTrans,
    parameter type obi_req_t = mgr_obi_req_t,
    parameter type obi_rsp_t = mgr_obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t sbr_req_i [NumMgr],
    output obi_rsp_t sbr_rsp_o [NumMgr],
    output obi_req_t mgr_req_o,
    input  obi_rsp_t mgr_rsp_i,
    output logic     idle_o,
    output logic     spurious_rsp_o
);

    localparam int unsigned IdxW = idx_width(NumMgr);

    logic [NumMgr-1:0] req_vec;
    logic              cand_valid;
    logic [IdxW-1:0]   cand_idx;
    logic              winner_valid;
    logic [IdxW-1:0]   winner;
    logic              req_valid;
    logic              handshake;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [IdxW-1:0]   fifo_head;
    lock_state_e       state_q;
    lock_state_e       state_d;
    logic [IdxW-1:0]   lock_idx;
    logic              locked;

    always_comb begin
        for (int i = 0; i < int'(NumMgr); i++) begin
            req_vec[i] = sbr_req_i[i].req;
        end
    end

`ifdef USER_MGR_ARB_FIXED_PRIO_EN
    // Downward scan so the lowest requesting index is the last one written.
    always_comb begin
        cand_idx = '0;
        for (int i = int'(NumMgr) - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                cand_idx = IdxW'(i);
            end
        end
        cand_valid = |req_vec;
    end
`else
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] hi_idx;
    logic [IdxW-1:0] lo_idx;
    logic            hi_valid;

    // Wrap-around search: lowest requester at or above rr_ptr, else lowest overall.
    always_comb begin
        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NumMgr) - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                lo_idx = IdxW'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_valid = 1'b1;
                    hi_idx   = IdxW'(i);
                end
            end
        end
        cand_valid = |req_vec;
        cand_idx   = hi_valid ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (winner == IdxW'(NumMgr - 1)) ? '0 : winner + IdxW'(1);
        end
    end
`endif

    // A pending ungranted request keeps its slot even if it stops being the
    // arbiter's choice; OBI requires the address phase to stay stable.
    always_comb begin
        if (locked) begin
            winner       = lock_idx;
            winner_valid = req_vec[lock_idx];
        end else begin
            winner       = cand_idx;
            winner_valid = cand_valid;
        end
    end

    // Full blocks issue even when a pop frees a slot this cycle; keeps the
    // request independent of rvalid.
    assign req_valid = winner_valid && !fifo_full;
    assign handshake = req_valid && mgr_rsp_i.gnt;

    always_comb begin
        mgr_req_o     = sbr_req_i[winner];
        mgr_req_o.req = req_valid;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= UNLOCKED;
            lock_idx <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == UNLOCKED && state_d == LOCKED) begin
                lock_idx <= winner;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UNLOCKED: if (req_valid && !mgr_rsp_i.gnt) state_d = LOCKED;
            LOCKED:   if (handshake) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    assign fifo_pop = mgr_rsp_i.rvalid && !fifo_empty;

    user_mgr_arb_id_fifo #(
        .Depth (MaxTrans),
        .Width (IdxW)
    ) i_id_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (handshake),
        .wdata (winner),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        for (int i = 0; i < int'(NumMgr); i++) begin
            sbr_rsp_o[i]     = '0;
            sbr_rsp_o[i].gnt = handshake && (winner == IdxW'(i));
            if (fifo_pop && (fifo_head == IdxW'(i))) begin
                sbr_rsp_o[i].rvalid = 1'b1;
                sbr_rsp_o[i].r      = mgr_rsp_i.r;
            end
        end
    end

    assign idle_o         = fifo_empty && !(|req_vec);
    assign spurious_rsp_o = mgr_rsp_i.rvalid && fifo_empty;

endmodule

// File: tb/tb_user_mgr_arbiter.sv
module tb_user_mgr_arbiter;
    import user_mgr_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int MT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    mgr_obi_req_t sbr_req [N];
    mgr_obi_rsp_t sbr_rsp [N];
    mgr_obi_req_t mgr_req;
    mgr_obi_rsp_t mgr_rsp;
    logic         idle;
    logic         spurious;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    user_mgr_arbiter #(.NumMgr(N), .MaxTrans(MT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sbr_req_i      (sbr_req),
        .sbr_rsp_o      (sbr_rsp),
        .mgr_req_o      (mgr_req),
        .mgr_rsp_i      (mgr_rsp),
        .idle_o         (idle),
        .spurious_rsp_o (spurious)
    );

    // ---------------- reference model ----------------
    // Outstanding issuers as a queue; arbitration from "who was granted last".
    int m_q[$];
    int m_last;
    int m_lock;
    int last_hs_idx;
    bit fixed_prio;

    typedef struct {
        bit req_out;
        int w;
        bit hs;
        int route;
        bit sp;
        bit idle;
    } m_out_t;

    task automatic model_reset();
        m_q.delete();
        m_last      = N - 1;
        m_lock      = -1;
        last_hs_idx = -1;
    endtask

    function automatic m_out_t model_eval();
        m_out_t o;
        bit     any;
        any     = 1'b0;
        o.w     = -1;
        o.route = -1;
        for (int i = 0; i < N; i++) any |= sbr_req[i].req;
        if (m_lock >= 0) begin
            if (sbr_req[m_lock].req) o.w = m_lock;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = fixed_prio ? (k - 1) : ((m_last + k) % N);
                if (o.w < 0 && sbr_req[i].req) o.w = i;
            end
        end
        o.req_out = (o.w >= 0) && (m_q.size() < MT);
        o.hs      = o.req_out && mgr_rsp.gnt;
        if (mgr_rsp.rvalid && m_q.size() > 0) o.route = m_q[0];
        o.sp   = mgr_rsp.rvalid && (m_q.size() == 0);
        o.idle = (m_q.size() == 0) && !any;
        return o;
    endfunction

    task automatic model_step();
        m_out_t o;
        o = model_eval();
        if (o.route >= 0) void'(m_q.pop_front());
        if (o.hs) begin
            m_q.push_back(o.w);
            m_last = o.w;
            m_lock = -1;
        end else if (o.req_out) begin
            m_lock = o.w;
        end
        last_hs_idx = o.hs ? o.w : -1;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] rq, input logic g, input logic rv, input logic [31:0] rd);
        for (int i = 0; i < N; i++) begin
            sbr_req[i].req     = rq[i];
            sbr_req[i].a.addr  = 32'h1000 * (i + 1);
            sbr_req[i].a.we    = 1'b1;
            sbr_req[i].a.be    = 4'hF;
            sbr_req[i].a.wdata = 32'hA5A5_0000 + i;
            sbr_req[i].a.aid   = 1'(i);
        end
        mgr_rsp.gnt     = g;
        mgr_rsp.rvalid  = rv;
        mgr_rsp.r.rdata = rd;
        mgr_rsp.r.err   = 1'b0;
        mgr_rsp.r.rid   = 1'b0;
    endtask

    task automatic check_cycle(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic [N-1:0] e_gnt, input logic [N-1:0] e_rv,
                               input logic e_idle, input logic e_sp);
        logic [N-1:0] a_gnt, a_rv;
        #1;
        for (int i = 0; i < N; i++) begin
            a_gnt[i] = sbr_rsp[i].gnt;
            a_rv[i]  = sbr_rsp[i].rvalid;
        end
        chk({tag, " req"}, 32'(mgr_req.req), 32'(e_req));
        if (e_req) chk({tag, " addr"}, mgr_req.a.addr, e_addr);
        chk({tag, " gnt"}, 32'(a_gnt), 32'(e_gnt));
        chk({tag, " rvalid"}, 32'(a_rv), 32'(e_rv));
        for (int i = 0; i < N; i++)
            chk({tag, " rdata"}, sbr_rsp[i].r.rdata, e_rv[i] ? mgr_rsp.r.rdata : 32'h0);
        chk({tag, " idle"}, 32'(idle), 32'(e_idle));
        chk({tag, " spurious"}, 32'(spurious), 32'(e_sp));
    endtask

    task automatic check_model(input string tag);
        m_out_t       o;
        logic [N-1:0] e_gnt, e_rv;
        logic [31:0]  e_addr;
        o      = model_eval();
        e_gnt  = '0;
        e_rv   = '0;
        e_addr = 32'h0;
        if (o.hs) e_gnt[o.w] = 1'b1;
        if (o.route >= 0) e_rv[o.route] = 1'b1;
        if (o.w >= 0) e_addr = sbr_req[o.w].a.addr;
        check_cycle(tag, o.req_out, e_addr, e_gnt, e_rv, o.idle, o.sp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic         gnt;
        logic         rv;
        logic [31:0]  rdata;
        logic         e_req;
        logic [31:0]  e_addr;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rv;
        logic         e_idle;
        logic         e_sp;
    } vec_t;

    vec_t tbl [11];

    initial begin
`ifdef USER_MGR_ARB_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`else
        fixed_prio = 1'b0;
`endif
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0, 32'h0);
        model_reset();

        //            req    g     rv    rdata          e_req e_addr        e_gnt  e_rv   idle  sp
        tbl[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     2'b00, 2'b00, 1'b1, 1'b0};
        tbl[1]  = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1000,  2'b01, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{2'b00, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0,    2'b00, 2'b01, 1'b0, 1'b0};
        tbl[3]  = '{2'b00, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h0,    2'b00, 2'b00, 1'b1, 1'b1};
`ifdef USER_MGR_ARB_FIXED_PRIO_EN
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1000,  2'b01, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1000,  2'b01, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 32'h0,    2'b00, 2'b01, 1'b0, 1'b0};
        tbl[7]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1000,  2'b01, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 32'h0,    2'b00, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h0,    2'b00, 2'b01, 1'b0, 1'b0};
`else
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 32'h2000,  2'b10, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1000,  2'b01, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 32'h0,    2'b00, 2'b10, 1'b0, 1'b0};
        tbl[7]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 32'h2000,  2'b10, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 32'h0,    2'b00, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h0,    2'b00, 2'b10, 1'b0, 1'b0};
`endif
        tbl[10] = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     2'b00, 2'b00, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check_cycle("in_reset", 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 11; t++) begin
            drive(tbl[t].req, tbl[t].gnt, tbl[t].rv, tbl[t].rdata);
            check_cycle($sformatf("tbl%0d", t), tbl[t].e_req, tbl[t].e_addr,
                        tbl[t].e_gnt, tbl[t].e_rv, tbl[t].e_idle, tbl[t].e_sp);
            tick();
        end

        // Lock: mgr 1 stalled by gnt=0 keeps the port while mgr 0 joins.
        do_reset();
        drive(2'b10, 1'b0, 1'b0, 32'h0);
        check_cycle("lock0", 1'b1, 32'h2000, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        drive(2'b10, 1'b0, 1'b0, 32'h0);
        check_cycle("lock1", 1'b1, 32'h2000, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        check_cycle("lock2", 1'b1, 32'h2000, 2'b00, 2'b00, 1'b0, 1'b0);
        chk("lock2 wdata", mgr_req.a.wdata, 32'hA5A5_0001);
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_cycle("lock3", 1'b1, 32'h2000, 2'b10, 2'b00, 1'b0, 1'b0);
        tick();
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        check_cycle("lock4", 1'b1, 32'h1000, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        drive(2'b01, 1'b1, 1'b1, 32'hCAFE_0001);
        check_cycle("lock5", 1'b1, 32'h1000, 2'b01, 2'b10, 1'b0, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'hCAFE_0002);
        check_cycle("lock6", 1'b0, 32'h0, 2'b00, 2'b01, 1'b0, 1'b0);
        tick();

        // Continuous requests with gnt and rvalid every cycle: push+pop each cycle.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] eg, er;
            eg = fixed_prio ? 2'b01 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            er = (k == 0) ? 2'b00 : (fixed_prio ? 2'b01 : ((k % 2 == 1) ? 2'b01 : 2'b10));
            drive(2'b11, 1'b1, (k > 0), 32'hB000_0000 + k);
            check_cycle($sformatf("alt%0d", k), 1'b1, eg[0] ? 32'h1000 : 32'h2000, eg, er, 1'b0, 1'b0);
            tick();
        end

        // Reset with two transactions outstanding, then a late rvalid.
        do_reset();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_model("pre0");
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_model("pre1");
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_cycle("full", 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("busy before reset idle", 32'(idle), 32'd0);
        rst_n = 1'b0;
        check_cycle("async_rst", 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive('0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check_cycle("late_rsp", 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1);
        tick();
        drive('0, 1'b0, 1'b0, 32'h0);
        check_cycle("late_rsp_end", 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0);
        tick();

        // Random traffic against the model; managers hold req until granted.
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_hs_idx == i) sbr_req[i].req = 1'b0;
                if (!sbr_req[i].req && $urandom_range(0, 1) == 1) begin
                    sbr_req[i].req     = 1'b1;
                    sbr_req[i].a.addr  = $urandom;
                    sbr_req[i].a.wdata = $urandom;
                    sbr_req[i].a.we    = 1'($urandom_range(0, 1));
                end
            end
            mgr_rsp.gnt     = ($urandom_range(0, 3) != 0);
            mgr_rsp.rvalid  = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                               : ($urandom_range(0, 15) == 0);
            mgr_rsp.r.rdata = $urandom;
            check_model("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
